// File: rtl/counter_wrap_tracker_pkg.sv
// Shared definitions for the counter wrap tracker slice.
//   - state_t       : tracker FSM encoding (INIT / TRACK / ERROR)
//   - W_DEF/HI_MOD_DEF/HI_W_DEF : default widths and high-digit modulus
//   - eff_modulus   : modulus_in with 0 mapped to 2^w
//   - expected_next : legal successor of a count under a given modulus
// The helper functions work at MAX_W+1 bits so callers of any width up to
// MAX_W zero-extend into them and 2^w never overflows.
package counter_pkg;

  localparam int W_DEF      = 4;
  localparam int HI_MOD_DEF = 10;
  localparam int HI_W_DEF   = 4;
  localparam int MAX_W      = 16;

  typedef enum logic [1:0] {
    INIT  = 2'd0,
    TRACK = 2'd1,
    ERROR = 2'd2
  } state_t;

  function automatic logic [MAX_W:0] eff_modulus(input logic [MAX_W-1:0] modulus,
                                                  input int unsigned     w);
    logic [MAX_W:0] m;
    if (modulus == '0) m = (MAX_W+1)'(1) << w;
    else               m = {1'b0, modulus};
    return m;
  endfunction

  function automatic logic [MAX_W:0] expected_next(input logic [MAX_W-1:0] prev,
                                                    input logic [MAX_W:0]   m);
    logic [MAX_W:0] p;
    p = {1'b0, prev};
    if (p == m - 1'b1) return '0;
    return p + 1'b1;
  endfunction

endpackage

// File: rtl/counter_wrap_tracker_if.sv
// Bus between an upstream modulo counter (master) and the wrap tracker (slave).
//   clear      : synchronous clear of tracker state, active-high
//   count_in   : running upstream count (W bits)
//   modulus_in : upstream modulus, 0 means 2^W
//   wrap_pulse : one-cycle pulse per legal upstream wrap
//   hi_count   : high-order digit (HI_W bits)
//   carry_out  : one-cycle pulse when hi_count wraps to 0
//   seq_error  : sticky illegal-step flag
interface counter_wrap_tracker_if #(
  parameter int W    = 4,
  parameter int HI_W = 4
);
  logic            clear;
  logic [W-1:0]    count_in;
  logic [W-1:0]    modulus_in;
  logic            wrap_pulse;
  logic [HI_W-1:0] hi_count;
  logic            carry_out;
  logic            seq_error;

  modport master (
    output clear, count_in, modulus_in,
    input  wrap_pulse, hi_count, carry_out, seq_error
  );

  modport slave (
    input  clear, count_in, modulus_in,
    output wrap_pulse, hi_count, carry_out, seq_error
  );
endinterface

// File: rtl/counter_wrap_tracker_step_check.sv
// counter_step_check: combinational classifier of one upstream step.
//   prev_count : last accepted count
//   count_in   : newly sampled count
//   modulus_in : upstream modulus, 0 means 2^W
//   is_hold / is_step / is_wrap / is_illegal : exactly one is high
// A sample at or above the effective modulus is always illegal, even if it
// equals prev_count (the modulus may have shrunk underneath it).
module counter_step_check
  import counter_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic [W-1:0] prev_count,
  input  logic [W-1:0] count_in,
  input  logic [W-1:0] modulus_in,
  output logic         is_hold,
  output logic         is_step,
  output logic         is_wrap,
  output logic         is_illegal
);

  logic [MAX_W:0] m;
  logic [MAX_W:0] e;
  logic [MAX_W:0] cin;
  logic [MAX_W:0] pc;
  logic           in_range;
  logic           same;

  always_comb begin
    m          = eff_modulus(MAX_W'(modulus_in), W);
    e          = expected_next(MAX_W'(prev_count), m);
    cin        = (MAX_W+1)'(count_in);
    pc         = (MAX_W+1)'(prev_count);
    in_range   = (cin < m);
    same       = (cin == pc);
    is_hold    = in_range && same;
    is_step    = in_range && !same && (cin == e) && (e != '0);
    is_wrap    = in_range && !same && (cin == '0) && (pc == m - 1'b1) &&
                 (m >= (MAX_W+1)'(2));
    is_illegal = !(is_hold || is_step || is_wrap);
  end

endmodule

// File: rtl/counter_wrap_tracker.sv
// counter_wrap_tracker: follows an upstream W-bit modulo counter, converts
// each legal wrap into a one-cycle wrap_pulse, counts wraps in a local
// HI_MOD digit with carry_out, and latches seq_error on any illegal step.
//   clock : rising-edge clock
//   reset : asynchronous active-low reset
//   bus   : counter_wrap_tracker_if.slave (clear, count_in, modulus_in in;
//           wrap_pulse, hi_count, carry_out, seq_error out)
module counter_wrap_tracker
  import counter_pkg::*;
#(
  parameter int W      = W_DEF,
  parameter int HI_MOD = HI_MOD_DEF,
  parameter int HI_W   = HI_W_DEF
) (
  input  logic                  clock,
  input  logic                  reset,
  counter_wrap_tracker_if.slave bus
);

  state_t          state_q, state_d;
  logic [W-1:0]    prev_count, prev_d;
  logic [HI_W-1:0] hi_count, hi_d;
  logic            wrap_pulse, wrap_d;
  logic            carry_out, carry_d;
  logic            seq_error, err_d;

  logic is_hold, is_step, is_wrap, is_illegal;

  counter_step_check #(.W(W)) u_check (
    .prev_count (prev_count),
    .count_in   (bus.count_in),
    .modulus_in (bus.modulus_in),
    .is_hold    (is_hold),
    .is_step    (is_step),
    .is_wrap    (is_wrap),
    .is_illegal (is_illegal)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= INIT;
      prev_count <= '0;
      hi_count   <= '0;
      wrap_pulse <= 1'b0;
      carry_out  <= 1'b0;
      seq_error  <= 1'b0;
    end else begin
      state_q    <= state_d;
      prev_count <= prev_d;
      hi_count   <= hi_d;
      wrap_pulse <= wrap_d;
      carry_out  <= carry_d;
      seq_error  <= err_d;
    end
  end

  // Pulses default to 0 each cycle so they self-clear unless re-fired.
  always_comb begin
    state_d = state_q;
    prev_d  = prev_count;
    hi_d    = hi_count;
    wrap_d  = 1'b0;
    carry_d = 1'b0;
    err_d   = seq_error;

    if (bus.clear) begin
      // clear wins over any wrap or error classified this cycle
      state_d = INIT;
      prev_d  = '0;
      hi_d    = '0;
      err_d   = 1'b0;
    end else begin
      unique case (state_q)
        INIT: begin
          // first sample after reset/clear has no history to check against
          prev_d  = bus.count_in;
          state_d = TRACK;
        end
        TRACK: begin
          if (is_hold) begin
            prev_d = prev_count;
          end else if (is_step) begin
            prev_d = bus.count_in;
          end else if (is_wrap) begin
            prev_d = '0;
            wrap_d = 1'b1;
            if (hi_count == HI_W'(HI_MOD - 1)) begin
              hi_d    = '0;
              carry_d = 1'b1;
            end else begin
              hi_d = hi_count + 1'b1;
            end
          end else if (is_illegal) begin
            err_d   = 1'b1;
            state_d = ERROR;
          end
        end
        ERROR: begin
          // keep following upstream but report nothing until cleared
          prev_d = bus.count_in;
        end
        default: begin
          state_d = INIT;
        end
      endcase
    end
  end

  assign bus.wrap_pulse = wrap_pulse;
  assign bus.hi_count   = hi_count;
  assign bus.carry_out  = carry_out;
  assign bus.seq_error  = seq_error;

endmodule

// File: tb/tb_counter_wrap_tracker.sv
// Directed testbench for counter_wrap_tracker (W=4, HI_MOD=10, HI_W=4).
module tb_counter_wrap_tracker;

  logic clock;
  logic reset;
  int   n_cmp = 0;
  int   n_err = 0;
  int   pulses;
  int   carries;
  int   carry_k;

  counter_wrap_tracker_if #(.W(4), .HI_W(4)) bus_if ();

  counter_wrap_tracker #(.W(4), .HI_MOD(10), .HI_W(4)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus_if)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // drive one count per clock and tally wrap pulses
  task automatic run_counts(input int from, input int to);
    for (int v = from; v <= to; v++) begin
      bus_if.count_in = 4'(v);
      tick();
      if (bus_if.wrap_pulse) pulses++;
    end
  endtask

  initial begin
    reset             = 1'b0;
    bus_if.clear      = 1'b0;
    bus_if.count_in   = 4'd0;
    bus_if.modulus_in = 4'd10;
    #12;
    chk("rst_wrap",  32'(bus_if.wrap_pulse), 32'd0);
    chk("rst_hi",    32'(bus_if.hi_count),   32'd0);
    chk("rst_carry", 32'(bus_if.carry_out),  32'd0);
    chk("rst_err",   32'(bus_if.seq_error),  32'd0);
    tick();
    reset = 1'b1;

    // 0..9 at one step per two cycles, then wrap to 0
    pulses = 0;
    for (int v = 0; v <= 9; v++) begin
      bus_if.count_in = 4'(v);
      tick(); if (bus_if.wrap_pulse) pulses++;
      tick(); if (bus_if.wrap_pulse) pulses++;
    end
    chk("slow_no_early_wrap", 32'(pulses), 32'd0);
    bus_if.count_in = 4'd0;
    tick();
    chk("slow_wrap_pulse", 32'(bus_if.wrap_pulse), 32'd1);
    chk("slow_hi",         32'(bus_if.hi_count),   32'd1);
    chk("slow_carry",      32'(bus_if.carry_out),  32'd0);
    tick();
    chk("slow_pulse_clear", 32'(bus_if.wrap_pulse), 32'd0);
    chk("slow_err",         32'(bus_if.seq_error),  32'd0);

    // clear, then 100 consecutive counts
    bus_if.clear = 1'b1;
    tick();
    chk("clr_hi", 32'(bus_if.hi_count), 32'd0);
    bus_if.clear = 1'b0;
    tick();
    pulses = 0; carries = 0; carry_k = -1;
    for (int k = 0; k < 100; k++) begin
      bus_if.count_in = 4'((k + 1) % 10);
      tick();
      if (bus_if.wrap_pulse) pulses++;
      if (bus_if.carry_out) begin
        carries++;
        carry_k = k;
        chk("carry_hi_zero",   32'(bus_if.hi_count),   32'd0);
        chk("carry_with_wrap", 32'(bus_if.wrap_pulse), 32'd1);
      end
    end
    chk("run100_wraps",   32'(pulses),  32'd10);
    chk("run100_carries", 32'(carries), 32'd1);
    chk("run100_carry_k", 32'(carry_k), 32'd99);
    chk("run100_err",     32'(bus_if.seq_error), 32'd0);

    // one wrap to make hi_count nonzero, then illegal jump 3->7
    run_counts(1, 9);
    bus_if.count_in = 4'd0; tick();
    chk("pre_jump_hi", 32'(bus_if.hi_count), 32'd1);
    run_counts(1, 3);
    chk("pre_jump_err", 32'(bus_if.seq_error), 32'd0);
    bus_if.count_in = 4'd7; tick();
    chk("jump_err", 32'(bus_if.seq_error), 32'd1);
    pulses = 0;
    run_counts(8, 9);
    bus_if.count_in = 4'd0; tick();
    if (bus_if.wrap_pulse) pulses++;
    chk("err_no_wrap", 32'(pulses),             32'd0);
    chk("err_hi_frz",  32'(bus_if.hi_count),    32'd1);
    chk("err_sticky",  32'(bus_if.seq_error),   32'd1);
    bus_if.clear = 1'b1; tick();
    chk("err_clr_err", 32'(bus_if.seq_error), 32'd0);
    chk("err_clr_hi",  32'(bus_if.hi_count),  32'd0);
    bus_if.clear = 1'b0;
    tick();
    pulses = 0;
    run_counts(1, 9);
    bus_if.count_in = 4'd0; tick();
    chk("resume_wrap", 32'(bus_if.wrap_pulse), 32'd1);
    chk("resume_hi",   32'(bus_if.hi_count),   32'd1);

    // modulus_in=0 means 16
    bus_if.clear = 1'b1; bus_if.modulus_in = 4'd0; tick();
    bus_if.clear = 1'b0; tick();
    pulses = 0;
    run_counts(1, 15);
    chk("m16_no_early", 32'(pulses), 32'd0);
    bus_if.count_in = 4'd0; tick();
    chk("m16_wrap", 32'(bus_if.wrap_pulse), 32'd1);
    chk("m16_err",  32'(bus_if.seq_error),  32'd0);
    run_counts(1, 11);
    chk("m16_err_11", 32'(bus_if.seq_error), 32'd0);
    bus_if.modulus_in = 4'd10;
    bus_if.count_in   = 4'd12; tick();
    chk("m10_out_of_range", 32'(bus_if.seq_error), 32'd1);

    // clear coincident with a wrap at hi_count=9
    bus_if.clear = 1'b1; tick();
    bus_if.clear = 1'b0; bus_if.count_in = 4'd0; tick();
    for (int r = 0; r < 9; r++) begin
      run_counts(1, 9);
      bus_if.count_in = 4'd0; tick();
    end
    chk("hi_at_9", 32'(bus_if.hi_count), 32'd9);
    run_counts(1, 9);
    bus_if.count_in = 4'd0; bus_if.clear = 1'b1; tick();
    chk("clrwrap_hi",    32'(bus_if.hi_count),   32'd0);
    chk("clrwrap_wrap",  32'(bus_if.wrap_pulse), 32'd0);
    chk("clrwrap_carry", 32'(bus_if.carry_out),  32'd0);
    bus_if.clear = 1'b0; bus_if.count_in = 4'd5; tick();
    bus_if.count_in = 4'd6; tick();
    chk("clrwrap_init_load", 32'(bus_if.seq_error), 32'd0);

    // async reset mid-count with hi_count=5 and wrap_pulse high
    bus_if.clear = 1'b1; tick();
    bus_if.clear = 1'b0; bus_if.count_in = 4'd0; tick();
    for (int r = 0; r < 4; r++) begin
      run_counts(1, 9);
      bus_if.count_in = 4'd0; tick();
    end
    run_counts(1, 9);
    bus_if.count_in = 4'd0; tick();
    chk("pre_rst_wrap", 32'(bus_if.wrap_pulse), 32'd1);
    chk("pre_rst_hi",   32'(bus_if.hi_count),   32'd5);
    #2;
    reset = 1'b0;
    #1;
    chk("async_rst_wrap", 32'(bus_if.wrap_pulse), 32'd0);
    chk("async_rst_hi",   32'(bus_if.hi_count),   32'd0);
    chk("async_rst_err",  32'(bus_if.seq_error),  32'd0);
    tick();
    reset = 1'b1;
    bus_if.count_in = 4'd7; tick();
    bus_if.count_in = 4'd8; tick();
    chk("post_rst_init", 32'(bus_if.seq_error), 32'd0);
    bus_if.count_in = 4'd9; tick();
    bus_if.count_in = 4'd0; tick();
    chk("post_rst_wrap", 32'(bus_if.wrap_pulse), 32'd1);
    chk("post_rst_hi",   32'(bus_if.hi_count),   32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
